// File: rtl/serial_detect_pkg.sv
// Shared types and defaults for the serial "110" detector arbiter.
package serial_detect_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int WORD_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    FLUSH,
    REPORT
  } ctl_state_t;

  typedef enum logic [1:0] {
    DET_IDLE = 2'b00,
    DET_S1   = 2'b01,
    DET_S11  = 2'b10,
    DET_HIT  = 2'b11
  } det_state_t;

endpackage

// File: rtl/serial_seq_detector.sv
// Bit-serial Moore detector for the pattern "110"; overlapping matches count.
//   state    | meaning
//   DET_IDLE | no useful prefix seen
//   DET_S1   | last bit was a lone 1
//   DET_S11  | last two bits were 11
//   DET_HIT  | last three bits were 110
module serial_seq_detector
  import serial_detect_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic X,
  output logic det_hit
);

  det_state_t state;

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= DET_IDLE;
    end else if (en) begin
      case (state)
        DET_IDLE: state <= X ? DET_S1  : DET_IDLE;
        DET_S1:   state <= X ? DET_S11 : DET_IDLE;
        DET_S11:  state <= X ? DET_S11 : DET_HIT;
        DET_HIT:  state <= X ? DET_S1  : DET_IDLE;
        default:  state <= DET_IDLE;
      endcase
    end
  end

  assign det_hit = (state == DET_HIT);

endmodule

// File: rtl/serial_detect_arbiter.sv
// Round-robin arbiter that scans one requester word at a time through the
// shared "110" detector and reports the hit count with a done pulse.
//   state  | meaning
//   IDLE   | waiting for a request; arbitration happens on the leaving edge
//   LOAD   | grant shown, detector and hit count cleared
//   SHIFT  | WORD_W cycles feeding the latched word MSB-first
//   FLUSH  | pick up the detector result of the final bit
//   REPORT | done pulse, round-robin pointer advances
module serial_detect_arbiter
  import serial_detect_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = $clog2(WORD_W) + 1
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WORD_W-1:0]   data,
  output logic [N_REQ-1:0]          gnt,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(N_REQ)-1:0]  done_id,
  output logic [CNT_W-1:0]          hit_count
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [ID_W:0]    N_EXT    = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  ctl_state_t        state;
  logic [WORD_W-1:0] shift_reg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win_idx;
  logic              win_found;
  logic [ID_W:0]     cand;
  logic              det_hit;
  logic [WORD_W-1:0] words [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_word
    assign words[g] = data[g*WORD_W +: WORD_W];
  end

  // First set request at or above rr_ptr, wrapping past the top index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!win_found && req[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      winner    <= '0;
      rr_ptr    <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      hit_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state     <= LOAD;
            shift_reg <= words[win_idx];
            winner    <= win_idx;
            gnt       <= N_REQ'(1) << win_idx;
            busy      <= 1'b1;
            hit_count <= '0;
          end
        end
        LOAD: begin
          state   <= SHIFT;
          bit_cnt <= '0;
        end
        SHIFT: begin
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt + BIT_W'(1);
          if (det_hit) hit_count <= hit_count + CNT_W'(1);
          if (bit_cnt == LAST_BIT) state <= FLUSH;
        end
        FLUSH: begin
          if (det_hit) hit_count <= hit_count + CNT_W'(1);
          gnt     <= '0;
          done    <= 1'b1;
          done_id <= winner;
          state   <= REPORT;
        end
        REPORT: begin
          done   <= 1'b0;
          busy   <= 1'b0;
          rr_ptr <= (winner == LAST_ID) ? '0 : winner + ID_W'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  serial_seq_detector u_det (
    .clk     (clk),
    .clr     (clr | (state == LOAD)),
    .en      (state == SHIFT),
    .X       (shift_reg[WORD_W-1]),
    .det_hit (det_hit)
  );

endmodule

// File: tb/tb_serial_detect_arbiter.sv
// Randomized bench for serial_detect_arbiter against a word-level pattern-count model.
module tb_serial_detect_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int C = $clog2(W) + 1;

  logic              clk = 1'b0;
  logic              clr;
  logic [N-1:0]      req;
  logic [N*W-1:0]    data;
  logic [N-1:0]      gnt;
  logic              busy;
  logic              done;
  logic [$clog2(N)-1:0] done_id;
  logic [C-1:0]      hit_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int rr_model = 0;

  serial_detect_arbiter #(.N_REQ(N), .WORD_W(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .hit_count (hit_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Count every position where the MSB-first bit stream ends in 1,1,0.
  function automatic int count_110(input logic [W-1:0] w);
    int c = 0;
    for (int i = W - 1; i >= 2; i--)
      if (w[i] && w[i-1] && !w[i-2]) c++;
    return c;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int rr);
    for (int i = 0; i < N; i++)
      if (r[(rr + i) % N]) return (rr + i) % N;
    return 0;
  endfunction

  always @(negedge clk)
    if (clr === 1'b0) chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    rr_model = 0;
  endtask

  task automatic serve(input logic [N-1:0] r, input logic [N*W-1:0] d,
                       input bit hold, input bit drop, output int done_cyc);
    int exp_id, exp_cnt, guard;
    logic [W-1:0] w;
    done_cyc = -1;
    @(negedge clk);
    guard = 0;
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_wait", 32'(guard < 40), 32'd1);
    req = r;
    data = d;
    exp_id = pick(r, rr_model);
    w = d[exp_id*W +: W];
    exp_cnt = count_110(w);
    rr_model = (exp_id + 1) % N;
    @(posedge clk);
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (k <= W + 2) begin
        chk("gnt", 32'(gnt), 32'(1 << exp_id));
        chk("busy", 32'(busy), 32'd1);
        chk("done_early", 32'(done), 32'd0);
      end else begin
        chk("done", 32'(done), 32'd1);
        chk("done_id", 32'(done_id), 32'(exp_id));
        chk("hit_count", 32'(hit_count), 32'(exp_cnt));
        chk("gnt_report", 32'(gnt), 32'd0);
        done_cyc = cyc;
      end
      if (drop && k == 2) begin
        req = '0;
        data = $urandom;
      end
    end
    if (!hold) req = '0;
  endtask

  task automatic abort_scan();
    @(negedge clk);
    req = 4'b0001;
    data = {24'h0, 8'hDA};
    @(posedge clk);
    repeat (6) @(negedge clk);
    clr = 1'b1;
    req = '0;
    @(negedge clk);
    clr = 1'b0;
    rr_model = 0;
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hit", 32'(hit_count), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int dc, prev;
    logic [7:0] words_dir [5];
    logic [N-1:0] r;
    clr = 1'b1;
    req = '0;
    data = '0;
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_hit", 32'(hit_count), 32'd0);

    words_dir[0] = 8'hDA;
    words_dir[1] = 8'hDB;
    words_dir[2] = 8'hFE;
    words_dir[3] = 8'h00;
    words_dir[4] = 8'h06;
    for (int i = 0; i < 5; i++)
      serve(4'b0001, {24'h0, words_dir[i]}, 1'b0, 1'b0, dc);

    do_reset();
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      serve(4'b1111, {$urandom}, (i < 4), 1'b0, dc);
      if (prev >= 0) chk("done_spacing", 32'(dc - prev), 32'd12);
      prev = dc;
    end

    serve(4'b0010, {$urandom}, 1'b0, 1'b0, dc);
    serve(4'b1010, {$urandom}, 1'b0, 1'b0, dc);
    serve(4'b1010, {$urandom}, 1'b0, 1'b0, dc);

    abort_scan();
    serve(4'b0001, {24'h0, 8'hDA}, 1'b0, 1'b0, dc);

    serve(4'b0100, {8'h11, 8'hDB, 8'h22, 8'h33}, 1'b0, 1'b1, dc);

    for (int i = 0; i < 30; i++) begin
      r = 4'($urandom_range(1, 15));
      serve(r, {$urandom}, 1'b0, 1'($urandom_range(0, 1)), dc);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_detect_arbiter.md
# serial_detect_arbiter

Round-robin arbiter and sequencer that shares one serial "110" pattern detector among several requesters. Each requester presents a parallel word. The block grants one requester at a time, shifts that word MSB-first through the detector, and counts the detector hits. It then returns the count with a one-cycle done pulse. It sits between the bit-serial detector core and the parallel clients that want pattern counts.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WORD_W, 8, bits per word scanned (>=3)
- CNT_W, $clog2(WORD_W)+1, width of hit_count
- clk  in  1  system clock; all state changes on the rising edge
- clr  in  1  synchronous active-high reset: one clock; reset is synchronous and active-high
- req  in  N_REQ  per-requester request, level-sensitive
- data  in  N_REQ*WORD_W  word of requester i at data[i*WORD_W +: WORD_W]
- gnt  out  N_REQ  one-hot grant; high LOAD through FLUSH
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in REPORT
- done_id  out  $clog2(N_REQ)  index of the requester that finished; valid when done=1
- hit_count  out  CNT_W  number of "110" detections in the word; valid when done=1

## Operation
- **Detector (sub-module):** Moore FSM with states IDLE=00, S1=01, S11=10, HIT=11.
  - Transitions, written as state(X=0 / X=1):
    - IDLE (IDLE / S1)
    - S1 (IDLE / S11)
    - S11 (HIT / S11)
    - HIT (IDLE / S1)
  - Output det_hit = (state==HIT). Overlapping matches count.
  - Advances only when en=1. A synchronous clear forces IDLE.
- **Controller FSM:** IDLE -> LOAD -> SHIFT -> FLUSH -> REPORT -> IDLE.
- **IDLE.** If req!=0, the winner is the first set req bit searching upward (wrapping) from rr_ptr.
  - At that edge: latch the winner's word into shift_reg, latch the winner index, and go to LOAD.
- **LOAD (1 cycle).**
  - gnt[winner]=1.
  - Detector cleared.
  - hit_count cleared to 0.
- **SHIFT (WORD_W cycles).**
  - Each cycle: detector X = shift_reg[WORD_W-1], en=1, shift_reg shifts left by 1, bit counter increments.
  - hit_count increments in every cycle where det_hit=1.
  - Leave after the bit counter reaches WORD_W-1.
- **FLUSH (1 cycle).**
  - en=0.
  - If det_hit=1 (result of the last bit), hit_count increments.
- **REPORT (1 cycle).**
  - done=1, done_id=winner, hit_count held, gnt=0.
  - rr_ptr = winner+1 mod N_REQ.
  - Next state is IDLE.
- **Requester behaviour during a scan.**
  - Deasserting req after the grant does not abort the scan; the latched word is scanned to completion.
  - Changes to data after the latch are ignored.
- **Reset values.** clr=1 at any edge, including mid-scan, forces:
  - FSM=IDLE, rr_ptr=0, gnt=0, busy=0, done=0, done_id=0, hit_count=0, detector=IDLE.
  - The interrupted scan produces no done pulse.
- **Width.** hit_count cannot overflow: there are at most floor(WORD_W/3)+1 < 2^CNT_W hits per word.

## Timing
- Arbitration is sampled at the edge leaving IDLE. gnt rises in the following cycle.
- Cycles per word: LOAD 1 + SHIFT WORD_W + FLUSH 1 + REPORT 1 = WORD_W+3 busy cycles, plus at least 1 IDLE cycle before the next grant.
  - Maximum throughput is one word per WORD_W+4 cycles (12 at default).
- For a request seen at edge e0: done is high in cycle e0+WORD_W+3.
- Simultaneous requests are resolved by rr_ptr only. After reset, requester 0 has highest priority.
- A requester that keeps req high is regranted only after every other pending requester has been served once.

## Structure
- Shared package serial_detect_pkg holds:
  - the controller state enum (IDLE, LOAD, SHIFT, FLUSH, REPORT);
  - the detector state encodings (IDLE..HIT);
  - the default N_REQ and WORD_W constants.
- One sub-module, serial_seq_detector (ports clk, clr, en, X, det_hit). The arbiter instantiates it once and drives its clr as (clr | state==LOAD).

## Test plan
- Reset, then req=4'b0001 with data0=8'hDA (11011010) -> gnt=0001 for 10 cycles, then done=1, done_id=0, hit_count=2.
- Single request with data=8'hDB (11011011) -> hit_count=2 (overlap via HIT->S1). data=8'hFE -> 1. data=8'h00 -> 0. data=8'h06 (00000110) -> 1, which checks the FLUSH-cycle count.
- req=4'b1111 held continuously -> done_id sequence 0,1,2,3,0. gnt is one-hot at all times, and done pulses are 12 cycles apart.
- req=4'b1010 after a serve of requester 1 (rr_ptr=2) -> next grant goes to requester 3, then requester 1.
- Assert clr during SHIFT bit 4 -> next cycle gnt=0, busy=0, hit_count=0, no done pulse. A fresh request with data=8'hDA again reports 2.
- Requester drops req and changes data one cycle after gnt rises -> the original latched word's count is still reported with its done_id.
